// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch port and
// the load/store port. One memory transaction is in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int   CNT_W  = 4;
    localparam logic WIN_IF = 1'b0;
    localparam logic WIN_D  = 1'b1;

    state_t           state_q, state_d;
    logic             win_q, win_d;
    logic             last_win_q, last_win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick;
    logic             issue_go;
    logic             resp_if, resp_d;

    // With both ports requesting, the one that did not win last time goes next.
    always_comb begin
        if (if_req && d_req) pick = ~last_win_q;
        else                 pick = d_req ? WIN_D : WIN_IF;
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_win_d = last_win_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    win_d   = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                last_win_d = win_q;
                cnt_d      = CNT_W'(MEM_LAT - 1);
                state_d    = (MEM_LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign issue_go = (state_q == IDLE) && (state_d == ISSUE);
    assign resp_if  = (state_q == RESP) && (win_q == WIN_IF);
    assign resp_d   = (state_q == RESP) && (win_q == WIN_D);

    // Every output is a register; grant and strobe are set on the IDLE->ISSUE edge.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= IDLE;
            win_q      <= WIN_IF;
            last_win_q <= WIN_D;
            cnt_q      <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_win_q <= last_win_d;
            cnt_q      <= cnt_d;
            if_gnt     <= issue_go && (pick == WIN_IF);
            d_gnt      <= issue_go && (pick == WIN_D);
            mem_en     <= issue_go;
            if_rvalid  <= resp_if;
            d_rvalid   <= resp_d;
            if (issue_go) begin
                mem_addr <= (pick == WIN_D) ? d_addr : if_addr;
                mem_we   <= (pick == WIN_D) && d_we;
                if (pick == WIN_D) mem_wdata <= d_wdata;
            end
            if (resp_if)            if_rdata <= mem_rdata;
            if (resp_d && !mem_we)  d_rdata  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=2 and one at MEM_LAT=1,
// each with a fixed-latency memory model returning a function of the address.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          nrst;
    int            checks;
    int            errors;

    // MEM_LAT = 2 instance
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // MEM_LAT = 1 instance
    logic          if_req1, if_gnt1, if_rvalid1;
    logic [AW-1:0] if_addr1;
    logic [DW-1:0] if_rdata1;
    logic          d_req1, d_we1, d_gnt1, d_rvalid1;
    logic [AW-1:0] d_addr1;
    logic [DW-1:0] d_wdata1, d_rdata1;
    logic          mem_en1, mem_we1;
    logic [AW-1:0] mem_addr1;
    logic [DW-1:0] mem_wdata1, mem_rdata1;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u_dut (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .nrst(nrst),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory models: data is valid only in the cycle exactly MEM_LAT after mem_en.
    logic [1:0]    mv0;
    logic [AW-1:0] ma0_0, ma0_1;
    logic          mv1;
    logic [AW-1:0] ma1;

    always @(posedge clk) begin
        if (nrst) begin
            mv0 <= 2'b00;
            mv1 <= 1'b0;
        end else begin
            mv0   <= {mv0[0], mem_en};
            ma0_0 <= mem_addr;
            ma0_1 <= ma0_0;
            mv1   <= mem_en1;
            ma1   <= mem_addr1;
        end
    end

    assign mem_rdata  = mv0[1] ? memf(ma0_1) : 32'hBAD0_BAD0;
    assign mem_rdata1 = mv1    ? memf(ma1)   : 32'hBAD0_BAD0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        nrst    = 1'b1;
        if_req  = 0; if_addr  = '0; d_req  = 0; d_we  = 0; d_addr  = '0; d_wdata  = '0;
        if_req1 = 0; if_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
        step(); step(); step();

        chk("rst_gnt",    {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_mem_en", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_addr",   mem_addr, 32'd0);
        chk("rst_wdata",  mem_wdata, 32'd0);
        chk("rst_if_rd",  if_rdata, 32'd0);
        chk("rst_d_rd",   d_rdata, 32'd0);
        nrst = 1'b0;
        step(); step();

        // Contention straight after reset: fetch first, then data
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        chk("c_if_gnt",  if_gnt, 1);
        chk("c_d_gnt0",  d_gnt, 0);
        chk("c_addr0",   mem_addr, 32'h40);
        if_req = 0;
        step(); step(); step();
        chk("c_if_rv",   if_rvalid, 1);
        chk("c_if_rd",   if_rdata, 32'hDEAD_BEEF);
        chk("c_d_gnt_e", d_gnt, 0);
        step();
        chk("c_d_gnt",   d_gnt, 1);
        chk("c_mem_en",  mem_en, 1);
        chk("c_addr1",   mem_addr, 32'h100);
        chk("c_we",      mem_we, 0);
        chk("c_if_rv0",  if_rvalid, 0);
        d_req = 0;
        step(); step(); step();
        chk("c_d_rv",    d_rvalid, 1);
        chk("c_d_rd",    d_rdata, 32'h5A5A_0100);
        step();
        chk("c_d_rv0",   d_rvalid, 0);

        // Single fetch
        if_req = 1; if_addr = 32'h40;
        step();
        chk("s_gnt",     if_gnt, 1);
        chk("s_en",      mem_en, 1);
        chk("s_addr",    mem_addr, 32'h40);
        chk("s_we",      mem_we, 0);
        if_req = 0;
        step();
        chk("s_gnt0",    if_gnt, 0);
        chk("s_en0",     mem_en, 0);
        step();
        chk("s_rv_early", if_rvalid, 0);
        step();
        chk("s_rv",      if_rvalid, 1);
        chk("s_rd",      if_rdata, 32'hDEAD_BEEF);
        step();
        chk("s_rv0",     if_rvalid, 0);

        // Second contention: fetch won last, so data goes first
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        chk("p_d_gnt",   d_gnt, 1);
        chk("p_if_gnt0", if_gnt, 0);
        chk("p_addr0",   mem_addr, 32'h100);
        d_req = 0;
        step(); step(); step();
        chk("p_d_rv",    d_rvalid, 1);
        step();
        chk("p_if_gnt",  if_gnt, 1);
        chk("p_addr1",   mem_addr, 32'h80);
        if_req = 0;
        step(); step(); step();
        chk("p_if_rv",   if_rvalid, 1);
        chk("p_if_rd",   if_rdata, 32'h5A5A_0080);
        step();

        // Write: d_rdata must keep its previous load value
        d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'h1234_5678;
        step();
        chk("w_gnt",     d_gnt, 1);
        chk("w_en",      mem_en, 1);
        chk("w_we",      mem_we, 1);
        chk("w_addr",    mem_addr, 32'h8);
        chk("w_wdata",   mem_wdata, 32'h1234_5678);
        d_req = 0; d_we = 0;
        step();
        chk("w_en0",     mem_en, 0);
        chk("w_hold",    mem_wdata, 32'h1234_5678);
        step();
        chk("w_rv_early", d_rvalid, 0);
        step();
        chk("w_rv",      d_rvalid, 1);
        chk("w_rd_keep", d_rdata, 32'h5A5A_0100);
        step();

        // Back-to-back fetches with if_req held: one grant every 4 cycles
        if_req = 1; if_addr = 32'h40;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("b2b_gnt_%0d", k), if_gnt, (k % 4 == 1) ? 1 : 0);
            chk($sformatf("b2b_en_%0d", k),  mem_en, (k % 4 == 1) ? 1 : 0);
            chk($sformatf("b2b_rv_%0d", k),  if_rvalid, (k % 4 == 0) ? 1 : 0);
        end
        if_req = 0;
        step();
        chk("b2b_gnt_end", if_gnt, 0);
        step(); step();

        // Reset during WAIT abandons the transaction and restores last_win=DATA
        if_req = 1; if_addr = 32'h40;
        step();
        chk("r_gnt",     if_gnt, 1);
        if_req = 0;
        step();
        nrst = 1;
        step();
        nrst = 0;
        chk("r_en0",     mem_en, 0);
        chk("r_gnt0",    {30'd0, if_gnt, d_gnt}, 0);
        chk("r_if_rd0",  if_rdata, 0);
        step();
        chk("r_rv0_a",   {30'd0, if_rvalid, d_rvalid}, 0);
        step();
        chk("r_rv0_b",   {30'd0, if_rvalid, d_rvalid}, 0);
        if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        chk("r_fresh_if", if_gnt, 1);
        chk("r_fresh_d",  d_gnt, 0);
        if_req = 0;
        step(); step(); step();
        chk("r_if_rv",   if_rvalid, 1);
        chk("r_if_rd",   if_rdata, 32'h5A5A_0044);
        step();
        chk("r_d_gnt",   d_gnt, 1);
        d_req = 0;
        step(); step(); step();
        chk("r_d_rv",    d_rvalid, 1);
        step();

        // MEM_LAT=1 instance: grant at T+1, rvalid at T+3, one transaction per 3 cycles
        if_req1 = 1; if_addr1 = 32'h40;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("l1_gnt_%0d", k), if_gnt1, (k % 3 == 1) ? 1 : 0);
            chk($sformatf("l1_en_%0d", k),  mem_en1, (k % 3 == 1) ? 1 : 0);
            chk($sformatf("l1_rv_%0d", k),  if_rvalid1, (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 0) chk($sformatf("l1_rd_%0d", k), if_rdata1, 32'hDEAD_BEEF);
            chk($sformatf("l1_we_%0d", k),  {30'd0, mem_we1, d_gnt1}, 0);
            if (k == 7) if_req1 = 0;
        end
        chk("l1_d_side", {31'd0, d_rvalid1}, 0);
        chk("l1_d_rd",   d_rdata1, 0);
        chk("l1_wdata",  mem_wdata1, 0);
        chk("l1_addr",   mem_addr1, 32'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
